// File: rtl/pipeline_pkg.sv
// Shared types for the instruction-fetch front end.
package pipeline_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // 32-bit add that sticks at all-ones instead of wrapping
    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetched {pc,instr} pairs with push, pop, flush and occupancy count.
module fetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       push_data_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output logic [WIDTH-1:0]       head_data_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    wr_ptr_q;
    logic [CW-1:0]    count_q;
    logic             pop_ok;

    assign pop_ok      = pop_i && (count_q != '0);
    assign head_data_o = mem_q[rd_ptr_q];
    assign empty_o     = (count_q == '0);
    assign count_o     = count_q;

    // Pointer and count update; flush empties the buffer and drops same-edge push/pop
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_i, pop_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage, no reset needed since count gates visibility
    always_ff @(posedge clk) begin
        if (reset && !flush_i && push_i) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/pipeline_fetch_buffer.sv
// Instruction-fetch front end: PC, imem request, response buffering, decode handshake.
// Optional FETCH_PERF_EN adds perf_fetched / perf_flushed saturating counters.
module pipeline_fetch_buffer
    import pipeline_pkg::*;
#(
    parameter int unsigned XLEN    = pipeline_pkg::XLEN,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned PC_STEP = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [XLEN-1:0]        initial_address,
    input  logic                   tr,
    output logic                   imem_req,
    output logic [XLEN-1:0]        imem_addr,
    input  logic [XLEN-1:0]        imem_rdata,
    input  logic                   redirect_valid,
    input  logic [XLEN-1:0]        redirect_pc,
    output logic                   dec_valid,
    input  logic                   dec_ready,
    output logic [XLEN-1:0]        dec_pc,
    output logic [XLEN-1:0]        dec_instr,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic                   fetch_fault
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]            perf_fetched,
    output logic [31:0]            perf_flushed
`endif
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            inflight_q, inflight_d;

    logic [CW-1:0]     count;
    logic [CW-1:0]     level;
    logic [2*XLEN-1:0] head;
    logic              empty;
    logic              push;
    logic              pop;

    assign level     = count + CW'(inflight_q);
    assign imem_req  = (state_q == FETCH) && (level < CW'(DEPTH)) && !redirect_valid;
    assign imem_addr = pc_q;
    assign push      = inflight_q && !redirect_valid;
    assign pop       = dec_valid && dec_ready && !redirect_valid;

    assign dec_valid   = !empty;
    assign dec_pc      = head[2*XLEN-1:XLEN];
    assign dec_instr   = head[XLEN-1:0];
    assign occupancy   = count;
    assign fetch_fault = (state_q == FAULT);

    fetch_fifo #(
        .WIDTH (2 * XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i ({req_pc_q, imem_rdata}),
        .pop_i       (pop),
        .flush_i     (redirect_valid),
        .head_data_o (head),
        .empty_o     (empty),
        .count_o     (count)
    );

    // State, PC and in-flight tracking registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            pc_q       <= initial_address;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
        end
    end

    // Next-state: redirect reloads PC and kills the in-flight response; otherwise run/stop
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = inflight_q;
        if (redirect_valid) begin
            pc_d       = redirect_pc;
            inflight_d = 1'b0;
            if (redirect_pc[1:0] != 2'b00) state_d = FAULT;
            else                           state_d = tr ? FETCH : IDLE;
        end else begin
            case (state_q)
                IDLE:    if (tr)  state_d = FETCH;
                FETCH:   if (!tr) state_d = IDLE;
                default: state_d = state_q;
            endcase
            inflight_d = imem_req;
            if (imem_req) begin
                req_pc_d = pc_q;
                pc_d     = pc_q + XLEN'(PC_STEP);
            end
        end
    end

`ifdef FETCH_PERF_EN
    // Pushed-entry and redirect-discard counters
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            if (push) perf_fetched <= sat_add32(perf_fetched, 32'd1);
            if (redirect_valid)
                perf_flushed <= sat_add32(perf_flushed, 32'(count) + 32'(inflight_q));
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_fetch_buffer.sv
// Directed table-driven bench for pipeline_fetch_buffer (DEPTH=4, PC_STEP=4).
module tb_pipeline_fetch_buffer;

    logic        clk;
    logic        reset;
    logic [31:0] initial_address;
    logic        tr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_pc;
    logic [31:0] dec_instr;
    logic [2:0]  occupancy;
    logic        fetch_fault;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushed;
`endif

    int errors = 0;
    int checks = 0;
    int row    = -1;

    pipeline_fetch_buffer dut (
        .clk             (clk),
        .reset           (reset),
        .initial_address (initial_address),
        .tr              (tr),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .dec_valid       (dec_valid),
        .dec_ready       (dec_ready),
        .dec_pc          (dec_pc),
        .dec_instr       (dec_instr),
        .occupancy       (occupancy),
        .fetch_fault     (fetch_fault)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched    (perf_fetched),
        .perf_flushed    (perf_flushed)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    // One-cycle-latency instruction memory
    always @(posedge clk) imem_rdata <= imem_req ? instr_of(imem_addr) : 32'hDEAD_BEEF;

    typedef struct {
        logic        tr;
        logic        rdy;
        logic        redir;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [2:0]  e_occ;
        logic        e_fault;
    } vec_t;

    localparam int NV = 32;
    vec_t tbl [NV];

    function automatic vec_t mk(input logic t, input logic r, input logic rv, input logic [31:0] rp,
                                input logic q, input logic [31:0] a, input logic v,
                                input logic [31:0] p, input logic [2:0] o, input logic f);
        vec_t x;
        x.tr = t; x.rdy = r; x.redir = rv; x.rpc = rp;
        x.e_req = q; x.e_addr = a; x.e_valid = v; x.e_pc = p; x.e_occ = o; x.e_fault = f;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row=%0d actual=%h expected=%h", name, row, act, exp);
        end
    endtask

    initial begin
        //                t  r  rv rpc           req addr          v  pc            occ f
        tbl[0]  = mk(1, 0, 0, 32'h0,        0, 32'h100,      0, 32'h0,        0, 0);
        tbl[1]  = mk(1, 0, 0, 32'h0,        1, 32'h100,      0, 32'h0,        0, 0);
        tbl[2]  = mk(1, 0, 0, 32'h0,        1, 32'h104,      0, 32'h0,        0, 0);
        tbl[3]  = mk(1, 0, 0, 32'h0,        1, 32'h108,      1, 32'h100,      1, 0);
        tbl[4]  = mk(1, 0, 0, 32'h0,        1, 32'h10C,      1, 32'h100,      2, 0);
        tbl[5]  = mk(1, 0, 0, 32'h0,        0, 32'h110,      1, 32'h100,      3, 0);
        tbl[6]  = mk(1, 0, 0, 32'h0,        0, 32'h110,      1, 32'h100,      4, 0);
        tbl[7]  = mk(1, 0, 0, 32'h0,        0, 32'h110,      1, 32'h100,      4, 0);
        tbl[8]  = mk(1, 1, 0, 32'h0,        0, 32'h110,      1, 32'h100,      4, 0);
        tbl[9]  = mk(1, 1, 0, 32'h0,        1, 32'h110,      1, 32'h104,      3, 0);
        tbl[10] = mk(1, 1, 0, 32'h0,        1, 32'h114,      1, 32'h108,      2, 0);
        tbl[11] = mk(1, 1, 0, 32'h0,        1, 32'h118,      1, 32'h10C,      2, 0);
        tbl[12] = mk(1, 0, 0, 32'h0,        1, 32'h11C,      1, 32'h110,      2, 0);
        tbl[13] = mk(1, 0, 1, 32'h200,      0, 32'h120,      1, 32'h110,      3, 0);
        tbl[14] = mk(1, 0, 0, 32'h0,        1, 32'h200,      0, 32'h0,        0, 0);
        tbl[15] = mk(1, 0, 0, 32'h0,        1, 32'h204,      0, 32'h0,        0, 0);
        tbl[16] = mk(1, 0, 0, 32'h0,        1, 32'h208,      1, 32'h200,      1, 0);
        tbl[17] = mk(1, 0, 1, 32'h202,      0, 32'h20C,      1, 32'h200,      2, 0);
        tbl[18] = mk(1, 0, 0, 32'h0,        0, 32'h202,      0, 32'h0,        0, 1);
        tbl[19] = mk(1, 0, 1, 32'h300,      0, 32'h202,      0, 32'h0,        0, 1);
        tbl[20] = mk(1, 0, 0, 32'h0,        1, 32'h300,      0, 32'h0,        0, 0);
        tbl[21] = mk(1, 1, 0, 32'h0,        1, 32'h304,      0, 32'h0,        0, 0);
        tbl[22] = mk(1, 1, 0, 32'h0,        1, 32'h308,      1, 32'h300,      1, 0);
        tbl[23] = mk(0, 1, 0, 32'h0,        1, 32'h30C,      1, 32'h304,      1, 0);
        tbl[24] = mk(0, 1, 0, 32'h0,        0, 32'h310,      1, 32'h308,      1, 0);
        tbl[25] = mk(0, 1, 0, 32'h0,        0, 32'h310,      1, 32'h30C,      1, 0);
        tbl[26] = mk(0, 1, 0, 32'h0,        0, 32'h310,      0, 32'h0,        0, 0);
        tbl[27] = mk(1, 1, 1, 32'hFFFF_FFFC, 0, 32'h310,     0, 32'h0,        0, 0);
        tbl[28] = mk(1, 1, 0, 32'h0,        1, 32'hFFFF_FFFC, 0, 32'h0,       0, 0);
        tbl[29] = mk(1, 1, 0, 32'h0,        1, 32'h0,        0, 32'h0,        0, 0);
        tbl[30] = mk(1, 1, 0, 32'h0,        1, 32'h4,        1, 32'hFFFF_FFFC, 1, 0);
        tbl[31] = mk(1, 1, 0, 32'h0,        1, 32'h8,        1, 32'h0,        1, 0);

        // Reset held with tr low
        reset           = 1'b0;
        initial_address = 32'h100;
        tr              = 1'b0;
        dec_ready       = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = 32'h0;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_req",   32'(imem_req),    32'd0);
        chk("rst_valid", 32'(dec_valid),   32'd0);
        chk("rst_occ",   32'(occupancy),   32'd0);
        chk("rst_fault", 32'(fetch_fault), 32'd0);
        chk("rst_addr",  imem_addr,        32'h100);
`ifdef FETCH_PERF_EN
        chk("rst_perf_fetched", perf_fetched, 32'd0);
        chk("rst_perf_flushed", perf_flushed, 32'd0);
`endif
        reset = 1'b1;

        // Directed vectors: inputs applied, outputs checked in the same cycle before the edge
        for (int i = 0; i < NV; i++) begin
            row            = i;
            tr             = tbl[i].tr;
            dec_ready      = tbl[i].rdy;
            redirect_valid = tbl[i].redir;
            redirect_pc    = tbl[i].rpc;
            #1;
            chk("imem_req",    32'(imem_req),    32'(tbl[i].e_req));
            chk("imem_addr",   imem_addr,        tbl[i].e_addr);
            chk("dec_valid",   32'(dec_valid),   32'(tbl[i].e_valid));
            chk("occupancy",   32'(occupancy),   32'(tbl[i].e_occ));
            chk("fetch_fault", 32'(fetch_fault), 32'(tbl[i].e_fault));
            if (tbl[i].e_valid) begin
                chk("dec_pc",    dec_pc,    tbl[i].e_pc);
                chk("dec_instr", dec_instr, instr_of(tbl[i].e_pc));
            end
            @(posedge clk);
            #1;
        end

        row            = 100;
        redirect_valid = 1'b0;
`ifdef FETCH_PERF_EN
        // 16 pushes in total; redirects discarded 3+1 and 2+1 entries
        chk("perf_fetched", perf_fetched, 32'd16);
        chk("perf_flushed", perf_flushed, 32'd7);
`endif

        // Reset wins over a simultaneous misaligned redirect
        row            = 101;
        reset          = 1'b0;
        tr             = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h502;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        #1;
        chk("rstov_addr",  imem_addr,        32'h100);
        chk("rstov_req",   32'(imem_req),    32'd0);
        chk("rstov_occ",   32'(occupancy),   32'd0);
        chk("rstov_valid", 32'(dec_valid),   32'd0);
        chk("rstov_fault", 32'(fetch_fault), 32'd0);
`ifdef FETCH_PERF_EN
        chk("rstov_perf_fetched", perf_fetched, 32'd0);
        chk("rstov_perf_flushed", perf_flushed, 32'd0);
`endif

        // Release with tr high: request 0x100 follows one edge later
        row   = 102;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("restart_req",  32'(imem_req), 32'd1);
        chk("restart_addr", imem_addr,     32'h100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
